// File: rtl/tile_sum_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tile_sum_sched
// Purpose : Per-tile luminance accumulation with per-row flush to a shared,
//           per-frame ping-ponged single-port tile memory plus reader arbitration.
// Rev     : 1.0  initial release
// ============================================================================
module tile_sum_sched #(
  parameter  int HBLKS = 10,
  parameter  int VBLKS = 10,
  parameter  int SW    = 20,
  localparam int HW    = $clog2(HBLKS),
  localparam int VW    = $clog2(VBLKS),
  localparam int TW    = $clog2(HBLKS*VBLKS),
  localparam int AW    = TW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          vs_i,
  input  logic          h_save_i,
  input  logic          v_save_i,
  input  logic [HW-1:0] ht_cur_i,
  input  logic [VW-1:0] vt_cur_i,
  input  logic [SW-1:0] seg_sum_i,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [SW-1:0] mem_wdata_o,
  input  logic [SW-1:0] mem_rdata_i,
  input  logic          rd_req_i,
  input  logic [TW-1:0] rd_addr_i,
  output logic          rd_gnt_o,
  output logic          rd_valid_o,
  output logic [SW-1:0] rd_data_o,
  output logic          bank_o,
  output logic          busy_o,
  output logic          ovf_o
);

  localparam logic [0:0]    S_IDLE     = 1'b0;
  localparam logic [0:0]    S_FLUSH    = 1'b1;
  localparam logic [HW-1:0] c_last_col = HW'(HBLKS - 1);
  localparam logic [HW:0]   c_hblks    = (HW+1)'(HBLKS);
  localparam logic [TW:0]   c_ntiles   = (TW+1)'(HBLKS * VBLKS);

  logic [SW-1:0] r_acc [HBLKS];
  logic [SW-1:0] r_buf [HBLKS];
  logic [SW-1:0] w_next [HBLKS];
  logic [SW-1:0] w_sel;
  logic [SW:0]   w_sum;
  logic [SW-1:0] w_sat;
  logic          w_hvalid;

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [HW-1:0] r_cnt;
  logic [VW-1:0] r_row;
  logic          r_wbank;
  logic          r_wr_pri;
  logic          r_vs_d;

  logic          w_wreq;
  logic          w_rd_ok;
  logic          w_rd_inv;
  logic          w_wgnt;
  logic          w_rgnt_mem;
  logic          w_rgnt_inv;
  logic          w_snap;
  logic          w_last;
  logic [TW-1:0] w_widx;
  logic [SW-1:0] w_wsel;

  // Single saturating adder shared by all columns; only one segment ends per cycle.
  assign w_hvalid = h_save_i && !vs_i && ({1'b0, ht_cur_i} < c_hblks);

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < HBLKS; i++) begin
      if (ht_cur_i == HW'(i)) w_sel = r_acc[i];
    end
  end

  assign w_sum = {1'b0, w_sel} + {1'b0, seg_sum_i};
  assign w_sat = w_sum[SW] ? '1 : w_sum[SW-1:0];

  always_comb begin
    for (int i = 0; i < HBLKS; i++) begin
      w_next[i] = (w_hvalid && (ht_cur_i == HW'(i))) ? w_sat : r_acc[i];
    end
  end

  assign w_snap = v_save_i && (r_state == S_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < HBLKS; i++) begin
        r_acc[i] <= '0;
        r_buf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < HBLKS; i++) begin
        r_acc[i] <= (vs_i || v_save_i) ? '0 : w_next[i];
        if (w_snap) r_buf[i] <= w_next[i];
      end
    end
  end

  // Port arbitration: out-of-range reads never touch memory, so they only take free cycles.
  assign w_wreq     = (r_state == S_FLUSH);
  assign w_rd_ok    = rd_req_i && ({1'b0, rd_addr_i} < c_ntiles);
  assign w_rd_inv   = rd_req_i && !w_rd_ok;
  assign w_wgnt     = w_wreq && (!w_rd_ok || r_wr_pri);
  assign w_rgnt_mem = w_rd_ok && (!w_wreq || !r_wr_pri);
  assign w_rgnt_inv = w_rd_inv && !w_wreq;
  assign rd_gnt_o   = w_rgnt_mem || w_rgnt_inv;
  assign w_last     = (r_cnt == c_last_col);

  assign w_widx = TW'(r_row) * TW'(HBLKS) + TW'(r_cnt);

  always_comb begin
    w_wsel = '0;
    for (int i = 0; i < HBLKS; i++) begin
      if (r_cnt == HW'(i)) w_wsel = r_buf[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (v_save_i) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_wgnt && w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (r_state == S_FLUSH);
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_wgnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = {r_wbank, w_widx};
      mem_wdata_o = w_wsel;
    end else if (w_rgnt_mem) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = {~r_bank_q(), rd_addr_i};
    end
  end

  function automatic logic r_bank_q();
    return bank_o;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_row      <= '0;
      r_wbank    <= 1'b0;
      r_wr_pri   <= 1'b0;
      r_vs_d     <= 1'b0;
      bank_o     <= 1'b0;
      ovf_o      <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      r_vs_d <= vs_i;
      if (vs_i && !r_vs_d) bank_o <= ~bank_o;
      if (w_snap) begin
        r_cnt   <= '0;
        r_row   <= vt_cur_i;
        r_wbank <= bank_o;
      end else if (w_wgnt) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (v_save_i && (r_state == S_FLUSH)) ovf_o <= 1'b1;
      // The loser of a conflict gets priority next time.
      if (w_wreq && w_rd_ok) r_wr_pri <= ~r_wr_pri;
      rd_valid_o <= rd_gnt_o;
      if (w_rgnt_mem)      rd_data_o <= mem_rdata_i;
      else if (w_rgnt_inv) rd_data_o <= '0;
    end
  end

endmodule
`default_nettype wire
